mips_run_ctrl: RTL and testbench

Run/step/halt controller for the single-cycle MIPS core. It gates the core's state-update enable so software-visible state advances only under command: free run, bounded run, single step, or halt on PC breakpoint. While halted it dumps all 32 register-file entries over a valid/ready stream. It sits between the bench or debug host and the `MIPS` top, driving the PC/RF/DM write enables and one RF read port.

---
 rtl/mips_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/step/halt controller for the single-cycle MIPS core.
// Gates the core's state-update enable (free run, bounded run, single step,
// PC breakpoint halt) and streams the 32 register-file entries while halted.
// Optional feature: define MIPS_RUN_CTRL_BP_EN to build the PC breakpoint
// logic; without it bp_addr is ignored and cause 2'b11 is never reported.
module mips_run_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [CNT_W-1:0]  i_cmd_arg,
  input  logic [ADDR_W-1:0] i_bp_addr,
  input  logic [ADDR_W-1:0] i_pc_in,
  output logic              o_cpu_en,
  output logic [4:0]        o_rf_raddr,
  input  logic [31:0]       i_rf_rdata,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [4:0]        o_dump_idx,
  output logic [31:0]       o_dump_data,
  output logic              o_halted,
  output logic [1:0]        o_halt_cause,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [1:0] C_STEP  = 2'b00;
  localparam logic [1:0] C_HALT  = 2'b01;
  localparam logic [1:0] C_LIMIT = 2'b10;
  localparam logic [1:0] C_BP    = 2'b11;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_remain;
  logic [4:0]       r_dump_idx;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic w_cmd_ready;
  logic w_cmd_acc;
  logic w_bp_hit;
  logic w_cpu_en;
  logic w_beat;

  // Command acceptance: anything from IDLE, only HALT while running.
  always_comb begin
    w_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_cmd_ready = 1'b1;
      S_RUN:   w_cmd_ready = (i_cmd_op == OP_HALT);
      default: w_cmd_ready = 1'b0;
    endcase
  end

  assign w_cmd_acc = i_cmd_valid && w_cmd_ready;

`ifdef MIPS_RUN_CTRL_BP_EN
  logic r_bp_skip;

  assign w_bp_hit = (i_pc_in == i_bp_addr) && !r_bp_skip;

  // Resuming from the breakpoint PC must execute that instruction once, so
  // the match is masked until the first enabled cycle has retired it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_bp_skip <= 1'b0;
    else if (r_state == S_IDLE && w_cmd_acc && i_cmd_op == OP_RUN)
      r_bp_skip <= (i_pc_in == i_bp_addr);
    else if (w_cpu_en)
      r_bp_skip <= 1'b0;
  end
`else
  logic w_unused_bp;

  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{i_bp_addr, i_pc_in};
`endif

  // Breakpoint cuts the enable in the matching cycle so that instruction
  // never commits.
  assign w_cpu_en = (r_state == S_RUN && !w_bp_hit) || (r_state == S_STEP);
  assign w_beat   = (r_state == S_DUMP) && i_dump_ready;

  // Control FSM: command decode, run exits in priority order, dump walk.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_remain   <= '0;
      r_dump_idx <= '0;
      r_cause    <= C_STEP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            case (i_cmd_op)
              OP_RUN: begin
                r_remain <= i_cmd_arg;
                r_state  <= S_RUN;
              end
              OP_STEP: r_state <= S_STEP;
              OP_DUMP: begin
                r_dump_idx <= '0;
                r_state    <= S_DUMP;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // A zero limit never reaches 1, so it runs until HALT/breakpoint.
          if (w_cpu_en && r_remain != '0)
            r_remain <= r_remain - CNT_W'(1);
          if (w_bp_hit) begin
            r_state <= S_IDLE;
            r_cause <= C_BP;
          end else if (w_cpu_en && r_remain == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_cause <= C_LIMIT;
          end else if (w_cmd_acc) begin
            r_state <= S_IDLE;
            r_cause <= C_HALT;
          end
        end
        S_STEP: begin
          r_state <= S_IDLE;
          r_cause <= C_STEP;
        end
        default: begin
          if (w_beat) begin
            r_dump_idx <= r_dump_idx + 5'd1;
            if (r_dump_idx == 5'd31)
              r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Retired-instruction counter, sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_cycle_cnt <= '0;
    else if (w_cpu_en && r_cycle_cnt != '1)
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_cpu_en      = w_cpu_en;
  assign o_rf_raddr    = r_dump_idx;
  assign o_dump_valid  = (r_state == S_DUMP);
  assign o_dump_idx    = r_dump_idx;
  assign o_dump_data   = i_rf_rdata;
  assign o_halted      = (r_state == S_IDLE);
  assign o_halt_cause  = r_cause;
  assign o_cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a toy core (PC += 4 per enabled cycle, array RF)
// around the controller; run outcomes are predicted from PC distance and
// limit arithmetic.
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_en;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  logic        pc_ld;
  logic [31:0] pc_ld_val;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;
  longint model_cnt = 0;

`ifdef MIPS_RUN_CTRL_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_run_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg),
    .i_bp_addr(bp_addr), .i_pc_in(pc),
    .o_cpu_en(cpu_en), .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata),
    .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
    .o_dump_idx(dump_idx), .o_dump_data(dump_data),
    .o_halted(halted), .o_halt_cause(halt_cause),
    .o_cycle_count(cycle_count)
  );

  // Toy core: PC advances one word per enabled cycle.
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign rf_rdata = rf[rf_raddr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk); pc_ld = 1'b1; pc_ld_val = v;
    @(negedge clk); pc_ld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    model_cnt = 0;
  endtask

  // Issue one command from IDLE and count enabled cycles until halted.
  // shape_ok drops if an enabled cycle follows a disabled one.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg,
                        output int n_en, output bit shape_ok);
    int t;
    bit seen_off;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_en = 0; shape_ok = 1'b1; seen_off = 1'b0; t = 0;
    while (!halted && t < 400) begin
      if (cpu_en) begin
        if (seen_off) shape_ok = 1'b0;
        n_en++;
      end else seen_off = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("cmd_done", halted, 1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] arg;
    logic [31:0] pc0;
    logic [31:0] bp;
    int          exp_en;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    bit ok;
    int exp_k;
    logic [1:0] exp_c;
    logic [31:0] pc0, bpv;
    int lim, d;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
    bp_addr = 32'hFFFF_0000; dump_ready = 1'b0; pc_ld = 1'b1; pc_ld_val = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[8] = 32'h0000_0008;

    // ---- reset state
    @(negedge clk); @(negedge clk);
    pc_ld = 1'b0;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_dump_idx", dump_idx, 0);
    chk("rst_halted", halted, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // ---- table-driven command vectors
    vt[0] = '{2'b00, 32'd5, 32'h0,   32'hFFFF_0000, 5, 2'b10};
    vt[1] = '{2'b01, 32'd0, 32'h40,  32'hFFFF_0000, 1, 2'b00};
    vt[2] = '{2'b01, 32'd0, 32'h44,  32'h48,        1, 2'b00};
    vt[3] = '{2'b01, 32'd0, 32'h80,  32'h80,        1, 2'b00};
    vt[4] = '{2'b10, 32'd0, 32'h0,   32'hFFFF_0000, 0, 2'b00};
    vt[5] = '{2'b00, 32'd1, 32'h0,   32'hFFFF_0000, 1, 2'b10};
    vt[6] = '{2'b10, 32'd0, 32'h0,   32'hFFFF_0000, 0, 2'b10};
    if (BP_EN) vt[7] = '{2'b00, 32'd3, 32'h100, 32'h108, 2, 2'b11};
    else       vt[7] = '{2'b00, 32'd3, 32'h100, 32'h108, 3, 2'b10};

    for (int v = 0; v < 8; v++) begin
      set_pc(vt[v].pc0);
      bp_addr = vt[v].bp;
      do_cmd(vt[v].op, vt[v].arg, n, ok);
      model_cnt += vt[v].exp_en;
      chk($sformatf("vec%0d_en", v), n, vt[v].exp_en);
      chk($sformatf("vec%0d_shape", v), ok, 1);
      chk($sformatf("vec%0d_cause", v), halt_cause, vt[v].exp_cause);
      chk($sformatf("vec%0d_count", v), cycle_count, model_cnt);
      chk($sformatf("vec%0d_pc", v), pc, vt[v].pc0 + 32'(4 * vt[v].exp_en));
    end

    // ---- unlimited RUN, STEP refused, HALT accepted in the 21st enabled cycle
    set_pc(32'h0); bp_addr = 32'hFFFF_0000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 32'd0;
    n = 0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (c <= 20) cmd_op = 2'b01;
      else if (c == 21) cmd_op = 2'b10;
      else cmd_valid = 1'b0;
      #1;
      if (cpu_en) n++;
      if (c == 5) chk("run_step_refused", cmd_ready, 0);
      if (c == 21) chk("run_halt_ready", cmd_ready, 1);
      if (c == 22) chk("run_halted_after", halted, 1);
    end
    model_cnt += 21;
    chk("halt_en_cycles", n, 21);
    chk("halt_cause", halt_cause, 2'b01);
    chk("halt_count", cycle_count, model_cnt);

    // ---- breakpoint at 0x10 from PC 0, then resume
    set_pc(32'h0); bp_addr = 32'h10;
    if (BP_EN) begin
      do_cmd(2'b00, 32'd0, n, ok);
      model_cnt += 4;
      chk("bp_en", n, 4);
      chk("bp_cause", halt_cause, 2'b11);
      chk("bp_pc", pc, 32'h10);
      do_cmd(2'b00, 32'd3, n, ok);
      model_cnt += 3;
      chk("bp_resume_en", n, 3);
      chk("bp_resume_cause", halt_cause, 2'b10);
      chk("bp_resume_pc", pc, 32'h1C);
    end else begin
      do_cmd(2'b00, 32'd8, n, ok);
      model_cnt += 8;
      chk("nobp_en", n, 8);
      chk("nobp_cause", halt_cause, 2'b10);
      chk("nobp_pc", pc, 32'h20);
    end
    chk("bp_count", cycle_count, model_cnt);

    // ---- randomized bounded runs against distance/limit arithmetic
    for (int r = 0; r < 16; r++) begin
      pc0 = 32'($urandom_range(0, 1000) * 4);
      lim = $urandom_range(1, 30);
      d   = $urandom_range(0, 40);
      bpv = pc0 + 32'(4 * d);
      if (BP_EN && d >= 1 && d < lim) begin exp_k = d; exp_c = 2'b11; end
      else begin exp_k = lim; exp_c = 2'b10; end
      set_pc(pc0); bp_addr = bpv;
      do_cmd(2'b00, 32'(lim), n, ok);
      model_cnt += exp_k;
      chk($sformatf("rnd%0d_en", r), n, exp_k);
      chk($sformatf("rnd%0d_shape", r), ok, 1);
      chk($sformatf("rnd%0d_cause", r), halt_cause, exp_c);
      chk($sformatf("rnd%0d_pc", r), pc, pc0 + 32'(4 * exp_k));
      chk($sformatf("rnd%0d_count", r), cycle_count, model_cnt);
    end

    // ---- DUMP with toggling ready
    begin
      int exp_idx, en_seen;
      bit prev_stall;
      logic [4:0] st_idx;
      logic [31:0] st_data;
      logic [1:0] cause_before;
      cause_before = halt_cause;
      exp_idx = 0; en_seen = 0; prev_stall = 1'b0; st_idx = '0; st_data = '0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 200; c++) begin
        dump_ready = (c % 2 == 0);
        #1;
        if (halted) break;
        if (cpu_en) en_seen++;
        if (!dump_valid) chk("dump_valid", dump_valid, 1);
        if (prev_stall) begin
          chk("stall_idx", dump_idx, st_idx);
          chk("stall_data", dump_data, st_data);
        end
        if (dump_ready) begin
          chk("dump_idx", dump_idx, exp_idx[4:0]);
          chk("dump_data", dump_data, rf[exp_idx[4:0]]);
          exp_idx++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1; st_idx = dump_idx; st_data = dump_data;
        end
        @(negedge clk);
      end
      dump_ready = 1'b0;
      chk("dump_beats", exp_idx, 32);
      chk("dump_halted", halted, 1);
      chk("dump_cpu_en", en_seen, 0);
      chk("dump_cause", halt_cause, cause_before);
      chk("dump_t0", rf[8], 32'h8);
    end

    // ---- reset mid-RUN
    set_pc(32'h0); bp_addr = 32'hFFFF_0000;
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 32'd0;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_running", cpu_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_en", cpu_en, 0);
    chk("midrun_rst_halted", halted, 1);
    chk("midrun_rst_count", cycle_count, 0);
    chk("midrun_rst_cause", halt_cause, 0);
    rst_n = 1'b1;

    // ---- reset mid-DUMP
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 2'b11; dump_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("middump_active", dump_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("middump_rst_valid", dump_valid, 0);
    chk("middump_rst_idx", dump_idx, 0);
    chk("middump_rst_halted", halted, 1);
    rst_n = 1'b1; dump_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
